// File: rtl/ttl_bcd_pkg.sv
// Segment patterns and BCD-to-7-segment decode shared by the scan display.
// Segment bit order: bit0=a ... bit6=g, active high.
package ttl_bcd_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Codes 10..15 are not BCD; show a dash so a bad counter is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ttl_bcd_seg_decode.sv
// Combinational 4-bit BCD to 7-segment decoder for the currently scanned digit.
module ttl_bcd_seg_decode
  import ttl_bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/ttl_bcd_scan_display.sv
// Multiplexed BCD display driver: latches DIGITS digits, scans them onto one 7-segment bus.
// Optional leading-zero blanking is enabled by defining TTL_BCD_SCAN_LEADING_ZERO_BLANK_EN.
module ttl_bcd_scan_display
  import ttl_bcd_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                  Clk,
  input  logic                  Clear,
  input  logic                  Strobe,
  input  logic                  Blank,
  input  logic [4*DIGITS-1:0]   D,
  output logic [6:0]            Segments,
  output logic [DIGITS-1:0]     Digit_select,
  output logic                  Frame
);

  localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
  localparam int PRES_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [PRES_W-1:0] PRES_LAST = PRES_W'(SCAN_DIV - 1);

  // Output delays are a board-level property; the synthesized outputs carry none.
  if (DIGITS < 1 || SCAN_DIV < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
    $error("ttl_bcd_scan_display: illegal parameter value");
  end

  logic [4*DIGITS-1:0] latch_q, latch_d;
  logic [PRES_W-1:0]   pres_q, pres_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic                wrap_q, wrap_d;
  logic                pres_wrap;
  logic [3:0]          digit_val;
  logic [6:0]          dec_seg;
  logic                lz_blank;
  logic [DIGITS-1:0]   sel_d;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;
  logic                frame_q;

  always_comb begin
    latch_d   = Strobe ? D : latch_q;
    pres_wrap = (pres_q == PRES_LAST);
    pres_d    = pres_wrap ? '0 : pres_q + PRES_W'(1);
    index_d   = index_q;
    if (pres_wrap) begin
      index_d = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);
    end
    wrap_d = pres_wrap && (index_q == IDX_LAST);
  end

  always_comb begin
    digit_val = 4'd0;
    sel_d     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (index_q == IDX_W'(i)) begin
        digit_val = latch_q[i*4 +: 4];
        sel_d[i]  = 1'b1;
      end
    end
  end

  ttl_bcd_seg_decode u_decode (
    .bcd_i (digit_val),
    .seg_o (dec_seg)
  );

`ifdef TTL_BCD_SCAN_LEADING_ZERO_BLANK_EN
  // zero_from[i] is set when digits i..DIGITS-1 are all zero (invalid codes are nonzero).
  logic [DIGITS-1:0] zero_from;

  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (latch_q[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (latch_q[i*4 +: 4] == 4'd0);
    end
  end

  assign lz_blank = (index_q != '0) && zero_from[index_q];
`else
  assign lz_blank = 1'b0;
`endif

  // Outputs sample index/latch from before the edge; Frame lags the index wrap by one
  // edge so it coincides with Digit_select returning to digit 0.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      latch_q <= '0;
      pres_q  <= '0;
      index_q <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      sel_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      latch_q <= latch_d;
      pres_q  <= pres_d;
      index_q <= index_d;
      wrap_q  <= wrap_d;
      frame_q <= wrap_q;
      if (Blank) begin
        seg_q <= SEG_OFF;
        sel_q <= '0;
      end else begin
        seg_q <= lz_blank ? SEG_OFF : dec_seg;
        sel_q <= sel_d;
      end
    end
  end

  assign Segments     = seg_q;
  assign Digit_select = sel_q;
  assign Frame        = frame_q;

endmodule

// File: tb/tb_ttl_bcd_scan_display.sv
// Self-checking bench for ttl_bcd_scan_display (DIGITS=4, SCAN_DIV=2) against a cycle-count model.
module tb_ttl_bcd_scan_display;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 2;
  localparam int FRAME_LEN = DIGITS * SCAN_DIV;

  logic        Clk    = 1'b0;
  logic        Clear  = 1'b1;
  logic        Strobe = 1'b0;
  logic        Blank  = 1'b0;
  logic [15:0] D      = 16'h0;
  logic [6:0]  Segments;
  logic [3:0]  Digit_select;
  logic        Frame;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  // Model state: edges since Clear released, and the digits latched so far.
  int          n = 0;
  logic [15:0] m_latch = 16'h0;
  logic [11:0] exp_w = 12'h0;
  logic [11:0] exp_q[$];

  ttl_bcd_scan_display #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .DELAY_RISE (0),
    .DELAY_FALL (0)
  ) dut (
    .Clk          (Clk),
    .Clear        (Clear),
    .Strobe       (Strobe),
    .Blank        (Blank),
    .D            (D),
    .Segments     (Segments),
    .Digit_select (Digit_select),
    .Frame        (Frame)
  );

  always #5 Clk = ~Clk;

  assign obs = {Frame, Digit_select, Segments};

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Drive one edge and compute what the display should show right after it.
  task automatic cycle(input logic clr, input logic stb, input logic blk, input logic [15:0] d);
    int idx;
    logic [6:0] seg;
    @(negedge Clk);
    Clear = clr; Strobe = stb; Blank = blk; D = d;
    if (clr) begin
      exp_w   = 12'h0;
      n       = 0;
      m_latch = 16'h0;
    end else begin
      n++;
      idx = ((n - 1) / SCAN_DIV) % DIGITS;
      seg = ref_seg(m_latch[idx*4 +: 4]);
`ifdef TTL_BCD_SCAN_LEADING_ZERO_BLANK_EN
      if (idx > 0 && (m_latch >> (4 * idx)) == 16'h0) seg = 7'h00;
`endif
      exp_w     = blk ? 12'h0 : {1'b0, 4'(1 << idx), seg};
      exp_w[11] = (n > 1) && ((n - 1) % FRAME_LEN == 0);
      if (stb) m_latch = d;
    end
    @(posedge Clk);
    #1;
  endtask

  // Reset, load d on the first free edge, then run to the end of that frame.
  task automatic load_and_settle(input logic [15:0] d);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, d);
    for (int i = 0; i < FRAME_LEN - 1; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, (i == 1), 1'b0, 16'h1234);
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got %h exp 000", i, obs);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 16'h1234);
    checks++;
    if (obs !== {1'b0, 4'b0001, 7'h3F}) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", obs, {1'b0, 4'b0001, 7'h3F});
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL reset_latch_zero cyc%0d got %h exp %h", i, obs, exp_w);
      end
    end
  endtask

  // Queue two frames of expected words from a per-digit segment list.
  task automatic push_frames(input logic [27:0] segs);
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < DIGITS; s++)
        for (int r = 0; r < SCAN_DIV; r++)
          exp_q.push_back({(s == 0 && r == 0), 4'(1 << s), segs[s*7 +: 7]});
  endtask

  task automatic test_pattern(input string name, input logic [15:0] d, input logic [27:0] segs);
    logic [11:0] e;
    load_and_settle(d);
    exp_q.delete();
    push_frames(segs);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      checks++;
      if (obs !== e || obs !== exp_w) begin
        errors++;
        $display("FAIL %s n%0d got %h exp %h model %h", name, n, obs, e, exp_w);
      end
    end
  endtask

  task automatic test_scan();
    int frames;
    int stray;
    test_pattern("scan_1234", 16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66});
    frames = 0;
    stray  = 0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      if (Frame === 1'b1) begin
        frames++;
        if (Digit_select !== 4'b0001) stray++;
      end
    end
    checks++;
    if (frames !== 2 || stray !== 0) begin
      errors++;
      $display("FAIL frame_rate got %0d pulses %0d misaligned exp 2 pulses 0 misaligned", frames, stray);
    end
  endtask

  task automatic test_invalid();
    test_pattern("invalid_FA90", 16'hFA90, {7'h40, 7'h40, 7'h6F, 7'h3F});
  endtask

  task automatic test_leading_zero();
`ifdef TTL_BCD_SCAN_LEADING_ZERO_BLANK_EN
    test_pattern("lz_0050", 16'h0050, {7'h00, 7'h00, 7'h6D, 7'h3F});
    test_pattern("lz_0000", 16'h0000, {7'h00, 7'h00, 7'h00, 7'h3F});
`else
    test_pattern("lz_0050", 16'h0050, {7'h3F, 7'h3F, 7'h6D, 7'h3F});
    test_pattern("lz_0000", 16'h0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F});
`endif
  endtask

  task automatic test_strobe_hold();
    load_and_settle(16'h1234);
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'($urandom));
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL strobe_hold n%0d got %h exp %h", n, obs, exp_w);
      end
    end
  endtask

  task automatic test_blank();
    load_and_settle(16'h9876);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 16'h0);
      checks++;
      if (obs[10:0] !== 11'h000 || obs !== exp_w) begin
        errors++;
        $display("FAIL blank_dark n%0d got %h exp %h", n, obs, exp_w);
      end
    end
    // Scan ran on underneath: edge 15 of this run lands in digit 3's slot.
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    checks++;
    if (Digit_select !== 4'b1000 || obs !== exp_w) begin
      errors++;
      $display("FAIL blank_resume got %h exp %h", obs, exp_w);
    end
  endtask

  task automatic test_mid_reset();
    int found;
    logic [3:0] exp_sel[3];
    exp_sel[0] = 4'b0001; exp_sel[1] = 4'b0001; exp_sel[2] = 4'b0010;
    load_and_settle(16'h1234);
    found = 0;
    for (int i = 0; i < 16 && found == 0; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      if (Digit_select === 4'b0100) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL mid_reset_reach got %b exp 0100 within 16 cycles", Digit_select);
    end
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_clear got %h exp 000", obs);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      checks++;
      if (Digit_select !== exp_sel[i] || obs !== exp_w) begin
        errors++;
        $display("FAIL mid_reset_restart cyc%0d got %h exp sel %b model %h", i, obs, exp_sel[i], exp_w);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 200; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 4; k++) d[k*4 +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 1) != 0) d[15:8] = 8'h00;
      end
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), d);
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL random n%0d got %h exp %h", n, obs, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_invalid();
    test_leading_zero();
    test_strobe_hold();
    test_blank();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
